func_sweep_checker: RTL
=======================

Name: func_sweep_checker

Overview:
- Self-checking harness stage wrapped around the 4-input combinational function block.
- Upstream role: drives the function's 4-bit input `x` with an exhaustive sweep, 0 to 15.
- Downstream role: samples `y` after a programmable settle time and compares it against an expected 16-entry truth table.
- Reports pass/fail, error count, the first failing index and a per-index error map. Used to qualify every realization variant, including transistor, NOR, NAND, Zhegalkin and ROM.

Parameters:
- EXPECTED, 16'hC855, expected truth table; bit i = required y for x == i (minterms 0,2,4,6,11,14,15).
- SETTLE, 2, idle cycles between driving x and sampling y; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- x  out  4  stimulus to the function block (registered).
- y  in  1  function output under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  high after a sweep if err_count == 0; held until the next start.
- err_count  out  5  number of mismatching vectors, 0..16.
- first_err  out  4  index of the first mismatch; valid only when err_count != 0.
- err_map  out  16  bit i set if the vector x == i mismatched.

Behaviour:
- Reset values: x=0, busy=0, done=0, pass=0, err_count=0, first_err=0, err_map=0, state=IDLE, settle counter=0.
- IDLE:
  - If start, go to SETTLE next edge.
  - On that edge: x <= 0, clear err_count/err_map/first_err/pass, busy <= 1, load settle counter with SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - When counter == 0, go to SAMPLE.
  - With SETTLE=0, SETTLE lasts exactly 1 cycle.
- SAMPLE (1 cycle): compare y against EXPECTED[x].
  - On mismatch: err_map[x] <= 1 and err_count++ (saturates at 16). If err_count was 0, first_err <= x.
  - If x == 15: go to DONE.
  - Otherwise: x <= x+1, reload counter, go to SETTLE.
- Timing: each vector occupies SETTLE+2 cycles (drive edge through sample edge). A full sweep is 16*(SETTLE+2) cycles from the start edge to the DONE entry.
- DONE (1 cycle):
  - done=1, busy <= 0, pass <= (err_count==0), go to IDLE.
  - x holds 15; results hold until the next accepted start.
- start while busy: ignored, no restart.
- start in the same cycle as DONE: ignored; accepted from IDLE next cycle.
- rst mid-sweep: all outputs immediately return to reset values; any partial results are discarded.
- y X/Z at sample: counts as a mismatch (compare with !==).

Optional Feature:
- Macro FUNC_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE. err_count=1, first_err and err_map reflect that vector, x holds the failing index, pass=0.
- Undefined: the full 16-vector sweep always runs.

Decomposition:
- Package func_sweep_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - N_VEC=16;
  - default truth table constant FUNC_TT=16'hC855;
  - counter width constants.
- One sub-module, func_sweep_timer: loadable down-counter for settle time, with load/zero interface.

Test Plan:
- Golden sweep: connect the NAND-realization function, SETTLE=2, pulse start. Expect done after 64 cycles, pass=1, err_count=0, err_map=0.
- Stuck output: drive y=0 constant. Expect err_count=7, err_map=16'hC855, first_err=0, pass=0.
- Single fault: y = f(x) except inverted at x=11. Expect err_count=1, first_err=11, err_map=16'h0800.
- SETTLE=0 timing: sweep completes in 32 cycles. x sequence 0..15 with each value held 2 cycles.
- Mid-sweep reset: assert rst at x=7. busy/x/err_map return to 0 asynchronously. A following start yields a fresh, correct sweep. start pulsed while busy causes no restart.
- With FUNC_SWEEP_STOP_ON_FAIL_EN and y inverted at x=4: done at the vector-4 sample, x=4, err_count=1, err_map=16'h0010.

Source files
------------

// File: rtl/func_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package func_sweep_pkg;

    localparam int unsigned N_VEC = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned ERR_W = 5;
    localparam int unsigned CNT_W = 4;

    localparam logic [N_VEC-1:0] FUNC_TT  = 16'hC855;
    localparam logic [IDX_W-1:0] IDX_LAST = 4'd15;
    localparam logic [ERR_W-1:0] ERR_MAX  = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/func_sweep_timer.sv
// Loadable settle-time down-counter; zero flags expiry.
// Latency: load takes effect on the next edge, zero is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches zero.
module func_sweep_timer
    import func_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/func_sweep_checker.sv
// Exhaustive 0..15 sweep of a 4-input function, checked against EXPECTED (FUNC_SWEEP_STOP_ON_FAIL_EN stops at first miss).
// Latency: SETTLE+2 cycles per vector, 16*(SETTLE+2) from start edge to done.
// Backpressure: start is only accepted in idle; requests while busy or in done are dropped.
module func_sweep_checker
    import func_sweep_pkg::*;
#(
    parameter logic [N_VEC-1:0] EXPECTED = FUNC_TT,
    parameter int unsigned      SETTLE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] x,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err,
    output logic [N_VEC-1:0] err_map
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] x_q, x_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [IDX_W-1:0] first_err_q, first_err_d;
    logic [N_VEC-1:0] err_map_q, err_map_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;
    logic mismatch;
    logic stop_now;

    func_sweep_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Four-state compare so an undriven or X output counts as a failure.
    assign mismatch = (y !== EXPECTED[x_q]);

`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = mismatch || (x_q == IDX_LAST);
`else
    assign stop_now = (x_q == IDX_LAST);
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        busy_d      = busy_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        err_map_d   = err_map_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    x_d         = '0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    first_err_d = '0;
                    err_map_d   = '0;
                    tmr_load    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_map_d[x_q] = 1'b1;
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    if (err_count_q == '0) begin
                        first_err_d = x_q;
                    end
                end
                if (stop_now) begin
                    state_d = ST_DONE;
                end else begin
                    x_d      = x_q + IDX_W'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                pass_d  = (err_count_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            err_map_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            err_map_q   <= err_map_d;
        end
    end

    assign x         = x_q;
    assign busy      = busy_q;
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign first_err = first_err_q;
    assign err_map   = err_map_q;

endmodule
